// File: rtl/maxnet_pkg.sv
// Shared definitions for the MAXNET winner-take-all block: FSM encoding and
// an elaboration-time ceiling-log2 helper.
package maxnet_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIter,
        StDone
    } state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/maxnet_pe.sv
// One MAXNET neuron: scales the sum of the other activations by eps and
// subtracts it from its own activation, saturating at zero.
module maxnet_pe #(
    parameter int unsigned W        = 8,
    parameter int unsigned SW       = 10,
    parameter int unsigned EPS_NUM  = 1,
    parameter int unsigned EPS_FRAC = 3
) (
    input  logic [W-1:0]  a,
    input  logic [SW-1:0] sum_others,
    output logic [W-1:0]  a_next,
    output logic          changed
);

    localparam int unsigned PW = SW + EPS_FRAC;

    logic [PW-1:0] prod;
    logic [SW-1:0] inhib;
    logic [SW-1:0] a_ext;

    always_comb begin
        prod    = PW'(EPS_NUM) * PW'(sum_others);
        inhib   = SW'(prod >> EPS_FRAC);
        a_ext   = SW'(a);
        a_next  = (inhib >= a_ext) ? '0 : W'(a_ext - inhib);
        changed = (a_next != a);
    end

endmodule

// File: rtl/maxnet_param.sv
// MAXNET winner-take-all: iterates mutual inhibition over N neurons until one
// survivor remains, the activations stall or collapse, or MAX_ITER is reached.
module maxnet_param
    import maxnet_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned W        = 8,
    parameter int unsigned EPS_NUM  = 1,
    parameter int unsigned EPS_FRAC = 3,
    parameter int unsigned MAX_ITER = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [N*W-1:0]                act_in,
    output logic                          busy,
    output logic                          done,
    output logic [clog2(N)-1:0]           winner,
    output logic                          winner_valid,
    output logic                          tie,
    output logic                          timeout,
    output logic [clog2(MAX_ITER+1)-1:0]  iter_count
);

    localparam int unsigned LN = clog2(N);
    localparam int unsigned IW = clog2(MAX_ITER + 1);
    localparam int unsigned CW = clog2(N + 1);
    localparam int unsigned SW = W + LN;

    state_e         state_q, state_d;
    logic [W-1:0]   a_q [N];
    logic [W-1:0]   a_d [N];
    logic [W-1:0]   a_next [N];
    logic [N-1:0]   changed;
    logic [IW-1:0]  iter_q, iter_d;
    logic [LN-1:0]  winner_q, winner_d;
    logic           valid_q, valid_d;
    logic           tie_q, tie_d;
    logic           timeout_q, timeout_d;

    logic [SW-1:0]  total;
    logic [CW-1:0]  nz_cnt;
    logic [LN-1:0]  nz_idx;

    // Sum-of-others is derived from one shared total to avoid N adder trees.
    always_comb begin
        total = '0;
        for (int i = 0; i < int'(N); i++) begin
            total = total + SW'(a_q[i]);
        end
    end

    for (genvar g = 0; g < int'(N); g++) begin : g_pe
        logic [SW-1:0] sum_others;
        assign sum_others = total - SW'(a_q[g]);

        maxnet_pe #(
            .W        (W),
            .SW       (SW),
            .EPS_NUM  (EPS_NUM),
            .EPS_FRAC (EPS_FRAC)
        ) u_pe (
            .a          (a_q[g]),
            .sum_others (sum_others),
            .a_next     (a_next[g]),
            .changed    (changed[g])
        );
    end

    // nz_idx is only meaningful when exactly one neuron is nonzero.
    always_comb begin
        nz_cnt = '0;
        nz_idx = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (a_q[i] != '0) begin
                nz_cnt = nz_cnt + CW'(1);
                nz_idx = LN'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        iter_d    = iter_q;
        winner_d  = winner_q;
        valid_d   = valid_q;
        tie_d     = tie_q;
        timeout_d = timeout_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    for (int i = 0; i < int'(N); i++) begin
                        a_d[i] = act_in[i*W +: W];
                    end
                    iter_d    = '0;
                    winner_d  = '0;
                    valid_d   = 1'b0;
                    tie_d     = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = StIter;
                end
            end
            StIter: begin
                if (nz_cnt == CW'(1)) begin
                    winner_d = nz_idx;
                    valid_d  = 1'b1;
                    state_d  = StDone;
                end else if (nz_cnt == '0) begin
                    valid_d = 1'b0;
                    tie_d   = (iter_q != '0);
                    state_d = StDone;
                end else if (iter_q == IW'(MAX_ITER)) begin
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end else if (changed == '0) begin
                    tie_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    a_d    = a_next;
                    iter_d = iter_q + IW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            iter_q    <= '0;
            winner_q  <= '0;
            valid_q   <= 1'b0;
            tie_q     <= 1'b0;
            timeout_q <= 1'b0;
            for (int i = 0; i < int'(N); i++) begin
                a_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            iter_q    <= iter_d;
            winner_q  <= winner_d;
            valid_q   <= valid_d;
            tie_q     <= tie_d;
            timeout_q <= timeout_d;
            for (int i = 0; i < int'(N); i++) begin
                a_q[i] <= a_d[i];
            end
        end
    end

    always_comb begin
        busy         = (state_q == StIter);
        done         = (state_q == StDone);
        winner       = winner_q;
        winner_valid = valid_q;
        tie          = tie_q;
        timeout      = timeout_q;
        iter_count   = iter_q;
    end

endmodule

// File: tb/tb_maxnet_param.sv
// Randomized and directed bench for maxnet_param against a behavioural model
// of the inhibition iteration.
module tb_maxnet_param;

    localparam int EPS_NUM  = 1;
    localparam int EPS_FRAC = 3;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] act_in;
    logic        busy;
    logic        done;
    logic [1:0]  winner;
    logic        winner_valid;
    logic        tie;
    logic        timeout;
    logic [7:0]  iter_count;

    logic        start2;
    logic [31:0] act_in2;
    logic        busy2;
    logic        done2;
    logic [1:0]  winner2;
    logic        winner_valid2;
    logic        tie2;
    logic        timeout2;
    logic [1:0]  iter_count2;

    int n_cmp;
    int n_err;

    maxnet_param dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .act_in       (act_in),
        .busy         (busy),
        .done         (done),
        .winner       (winner),
        .winner_valid (winner_valid),
        .tie          (tie),
        .timeout      (timeout),
        .iter_count   (iter_count)
    );

    maxnet_param #(
        .MAX_ITER (2)
    ) dut2 (
        .clk          (clk),
        .rst          (rst),
        .start        (start2),
        .act_in       (act_in2),
        .busy         (busy2),
        .done         (done2),
        .winner       (winner2),
        .winner_valid (winner_valid2),
        .tie          (tie2),
        .timeout      (timeout2),
        .iter_count   (iter_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Plays the competition out with plain integer arithmetic.
    function automatic void ref_model(input int act [4], input int max_iter,
                                      output int win, output int valid, output int tie_o,
                                      output int tmo, output int iters);
        int a [4];
        int an [4];
        int nz, idx, sum, inh;
        bit same;
        a = act;
        win = 0; valid = 0; tie_o = 0; tmo = 0; iters = 0;
        forever begin
            nz = 0; idx = 0; sum = 0;
            for (int i = 0; i < 4; i++) begin
                sum += a[i];
                if (a[i] != 0) begin
                    nz++;
                    idx = i;
                end
            end
            if (nz == 1) begin
                win = idx; valid = 1; return;
            end
            if (nz == 0) begin
                tie_o = (iters != 0); return;
            end
            if (iters == max_iter) begin
                tmo = 1; return;
            end
            same = 1'b1;
            for (int i = 0; i < 4; i++) begin
                inh = (EPS_NUM * (sum - a[i])) >> EPS_FRAC;
                an[i] = (a[i] > inh) ? a[i] - inh : 0;
                if (an[i] != a[i]) same = 1'b0;
            end
            if (same) begin
                tie_o = 1; return;
            end
            a = an;
            iters++;
        end
    endfunction

    task automatic run_case(input string tag, input int act [4], input bit poke);
        int ew, ev, et, eo, ei;
        int cyc;
        ref_model(act, 255, ew, ev, et, eo, ei);
        @(negedge clk);
        for (int i = 0; i < 4; i++) act_in[i*8 +: 8] = act[i][7:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check_eq({tag, ":busy"}, {31'd0, busy}, 32'd1);
        if (poke) begin
            act_in = $urandom;
            start  = 1'b1;
        end
        while (done !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) start = 1'b0;
        end
        start = 1'b0;
        check_eq({tag, ":latency"}, cyc, 2 + ei);
        check_eq({tag, ":busy_at_done"}, {31'd0, busy}, 32'd0);
        check_eq({tag, ":winner"}, {30'd0, winner}, ew);
        check_eq({tag, ":valid"}, {31'd0, winner_valid}, ev);
        check_eq({tag, ":tie"}, {31'd0, tie}, et);
        check_eq({tag, ":timeout"}, {31'd0, timeout}, eo);
        check_eq({tag, ":iter"}, {24'd0, iter_count}, ei);
        @(negedge clk);
        check_eq({tag, ":done_pulse"}, {31'd0, done}, 32'd0);
        check_eq({tag, ":hold_iter"}, {24'd0, iter_count}, ei);
        check_eq({tag, ":hold_valid"}, {31'd0, winner_valid}, ev);
    endtask

    initial begin
        int act [4];
        int cyc;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        start = 1'b0;
        start2 = 1'b0;
        act_in = '0;
        act_in2 = '0;
        repeat (2) @(negedge clk);
        check_eq("rst:busy", {31'd0, busy}, 32'd0);
        check_eq("rst:done", {31'd0, done}, 32'd0);
        check_eq("rst:flags", {29'd0, winner_valid, tie, timeout}, 32'd0);
        check_eq("rst:iter", {24'd0, iter_count}, 32'd0);
        rst = 1'b0;

        act = '{100, 80, 60, 40};
        run_case("unique", act, 1'b0);
        check_eq("unique:winner0", {30'd0, winner}, 32'd0);
        check_eq("unique:valid1", {31'd0, winner_valid}, 32'd1);
        act = '{0, 7, 0, 0};
        run_case("single", act, 1'b0);
        check_eq("single:winner1", {30'd0, winner}, 32'd1);
        check_eq("single:iter0", {24'd0, iter_count}, 32'd0);
        act = '{50, 50, 0, 0};
        run_case("equal", act, 1'b1);
        check_eq("equal:tie1", {31'd0, tie}, 32'd1);
        act = '{0, 0, 0, 0};
        run_case("zero", act, 1'b1);
        check_eq("zero:flags", {29'd0, winner_valid, tie, timeout}, 32'd0);

        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 4; i++) begin
                act[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
            end
            run_case($sformatf("rand%0d", t), act, t[0]);
        end

        // Abort mid-competition: no done pulse, everything cleared.
        act = '{100, 80, 60, 40};
        @(negedge clk);
        for (int i = 0; i < 4; i++) act_in[i*8 +: 8] = act[i][7:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("abort:busy_before", {31'd0, busy}, 32'd1);
        check_eq("abort:iter_before", {24'd0, iter_count}, 32'd3);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        check_eq("abort:busy", {31'd0, busy}, 32'd0);
        check_eq("abort:iter", {24'd0, iter_count}, 32'd0);
        check_eq("abort:flags", {29'd0, winner_valid, tie, timeout}, 32'd0);
        cyc = 0;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) cyc++;
        end
        check_eq("abort:quiet", cyc, 32'd0);

        // Iteration limit on the MAX_ITER=2 instance.
        @(negedge clk);
        act_in2 = {8'd97, 8'd98, 8'd99, 8'd100};
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        cyc = 1;
        while (done2 !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("limit:latency", cyc, 32'd4);
        check_eq("limit:timeout", {31'd0, timeout2}, 32'd1);
        check_eq("limit:iter", {30'd0, iter_count2}, 32'd2);
        check_eq("limit:valid_tie", {30'd0, winner_valid2, tie2}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
